// File: rtl/rdata_arbiter.sv
// Round-robin arbiter sharing one valid/ready/rdata read target among NREQ requesters.
// Optional watchdog abort of unanswered transactions is enabled by `define RDATA_ARB_TIMEOUT_EN.
module rdata_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 4,
    parameter int unsigned TO_CYCLES = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    output logic [DW-1:0]   req_rdata,
    output logic            tgt_valid,
    input  logic            tgt_ready,
    input  logic [DW-1:0]   tgt_rdata,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic            timeout
);

    localparam int unsigned PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 1) begin : g_param_check
        $error("rdata_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win_q, win_d;
    logic [NREQ-1:0] grant_d;
    logic [NREQ-1:0] req_ready_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            tgt_valid_d;
    logic            busy_d;
    logic            timeout_d;
    logic            sel_found_c;
    logic [PW-1:0]   sel_idx_c;
    logic [PW-1:0]   scan_idx_c;
    logic            abort_c;

    // Round-robin search starting one past the last winner, wrapping modulo NREQ.
    always_comb begin
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        scan_idx_c  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            scan_idx_c = PW'((32'(ptr_q) + i) % NREQ);
            if (!sel_found_c && req_valid[scan_idx_c]) begin
                sel_found_c = 1'b1;
                sel_idx_c   = scan_idx_c;
            end
        end
    end

`ifdef RDATA_ARB_TIMEOUT_EN
    localparam int unsigned CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    logic [CW-1:0] wd_cnt_q;

    // Counts stalled ISSUE cycles; held at zero outside ISSUE so every ISSUE starts fresh.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else if (state_q != ISSUE) begin
            wd_cnt_q <= '0;
        end else if (!tgt_ready) begin
            wd_cnt_q <= wd_cnt_q + CW'(1);
        end
    end

    assign abort_c = (state_q == ISSUE) && !tgt_ready && (wd_cnt_q == CW'(TO_CYCLES - 1));
`else
    assign abort_c = 1'b0;
`endif

    // Next-state and next-output decode; every output is registered from these.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        grant_d     = grant;
        rdata_d     = rdata_q;
        req_ready_d = '0;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_found_c) begin
                    state_d = ISSUE;
                    win_d   = sel_idx_c;
                    grant_d = NREQ'(1) << sel_idx_c;
                end
            end
            ISSUE: begin
                if (tgt_ready) begin
                    state_d     = RESP;
                    rdata_d     = tgt_rdata;
                    req_ready_d = grant;
                end else if (abort_c) begin
                    state_d     = RESP;
                    rdata_d     = '1;
                    req_ready_d = grant;
                    timeout_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = win_q;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        tgt_valid_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= PW'(NREQ - 1);
            win_q     <= '0;
            grant     <= '0;
            rdata_q   <= '0;
            req_ready <= '0;
            tgt_valid <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            grant     <= grant_d;
            rdata_q   <= rdata_d;
            req_ready <= req_ready_d;
            tgt_valid <= tgt_valid_d;
            busy      <= busy_d;
            timeout   <= timeout_d;
        end
    end

    assign req_rdata = rdata_q;

endmodule

// File: tb/tb_rdata_arbiter.sv
// Directed self-checking bench for rdata_arbiter (NREQ=4, DW=4, TO_CYCLES=15).
module tb_rdata_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [3:0] req_rdata;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] tgt_rdata;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    logic       auto_ready;
    logic       tgt_ready_drv;

    int n_checks = 0;
    int n_fail   = 0;

    assign tgt_ready = auto_ready ? tgt_valid : tgt_ready_drv;

    rdata_arbiter #(.NREQ(4), .DW(4), .TO_CYCLES(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_rdata (tgt_rdata),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        req_valid     = 4'b0000;
        auto_ready    = 1'b1;
        tgt_ready_drv = 1'b0;
        tgt_rdata     = 4'h0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_checks++;
        if ({tgt_valid, busy, timeout} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got tv/busy/to=%b expected 000", {tgt_valid, busy, timeout});
        end
        n_checks++;
        if (req_rdata !== 4'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", req_rdata); end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100;
        tgt_rdata = 4'h5;
        step();
        n_checks++;
        if (grant !== 4'b0100 || tgt_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_issue: got grant=%b tv=%b busy=%b expected 0100 1 1", grant, tgt_valid, busy);
        end
        step();
        n_checks++;
        if (req_ready !== 4'b0100 || req_rdata !== 4'h5) begin
            n_fail++; $display("FAIL single_resp: got ready=%b rdata=%h expected 0100 5", req_ready, req_rdata);
        end
        n_checks++;
        if (tgt_valid !== 1'b0) begin n_fail++; $display("FAIL single_tv_resp: got %b expected 0", tgt_valid); end
        req_valid = 4'b0000;
        step();
        n_checks++;
        if (busy !== 1'b0 || grant !== 4'b0000 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL single_idle: got busy=%b grant=%b ready=%b expected 0 0000 0000", busy, grant, req_ready);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            exp       = 4'b0001 << (k % 4);
            tgt_rdata = 4'(k + 1);
            step();
            n_checks++;
            if (grant !== exp) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b expected %b", k, grant, exp); end
            step();
            n_checks++;
            if (req_ready !== exp || req_rdata !== 4'(k + 1)) begin
                n_fail++; $display("FAIL fair_resp[%0d]: got ready=%b rdata=%h expected %b %h", k, req_ready, req_rdata, exp, 4'(k + 1));
            end
            step();
            n_checks++;
            if (busy !== 1'b0 || req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL fair_idle[%0d]: got busy=%b ready=%b expected 0 0000", k, busy, req_ready);
            end
        end
        req_valid = 4'b0000;
        step();
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid = 4'b1000;
        tgt_rdata = 4'h3;
        step();
        n_checks++;
        if (grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: got %b expected 1000", grant); end
        step();
        req_valid = 4'b1001;
        step();
        step();
        n_checks++;
        if (grant !== 4'b0001) begin n_fail++; $display("FAIL wrap_zero: got %b expected 0001", grant); end
        step();
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_zero_ready: got %b expected 0001", req_ready); end
        req_valid = 4'b1000;
        step();
        step();
        n_checks++;
        if (grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_three: got %b expected 1000", grant); end
        step();
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_stall();
        do_reset();
        auto_ready    = 1'b0;
        tgt_ready_drv = 1'b0;
        tgt_rdata     = 4'h0;
        req_valid     = 4'b0010;
        step();
        for (int c = 1; c <= 6; c++) begin
            n_checks++;
            if (tgt_valid !== 1'b1 || grant !== 4'b0010 || req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL stall_issue[%0d]: got tv=%b grant=%b ready=%b expected 1 0010 0000", c, tgt_valid, grant, req_ready);
            end
            if (c == 6) begin
                tgt_ready_drv = 1'b1;
                tgt_rdata     = 4'hA;
            end
            step();
        end
        n_checks++;
        if (req_ready !== 4'b0010 || req_rdata !== 4'hA || tgt_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_resp: got ready=%b rdata=%h tv=%b expected 0010 a 0", req_ready, req_rdata, tgt_valid);
        end
        req_valid     = 4'b0000;
        tgt_ready_drv = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_timeout();
        do_reset();
        auto_ready    = 1'b0;
        tgt_ready_drv = 1'b0;
        tgt_rdata     = 4'h6;
        req_valid     = 4'b0001;
        step();
`ifdef RDATA_ARB_TIMEOUT_EN
        for (int c = 1; c <= 15; c++) begin
            n_checks++;
            if (tgt_valid !== 1'b1 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL to_issue[%0d]: got tv=%b to=%b expected 1 0", c, tgt_valid, timeout);
            end
            step();
        end
        n_checks++;
        if (req_ready !== 4'b0001 || timeout !== 1'b1 || req_rdata !== 4'hF) begin
            n_fail++; $display("FAIL to_abort: got ready=%b to=%b rdata=%h expected 0001 1 f", req_ready, timeout, req_rdata);
        end
        req_valid = 4'b0000;
        step();
        n_checks++;
        if (timeout !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL to_after: got to=%b busy=%b expected 0 0", timeout, busy);
        end
        req_valid = 4'b0001;
        tgt_rdata = 4'h7;
        step();
        for (int c = 1; c <= 15; c++) begin
            if (c == 15) tgt_ready_drv = 1'b1;
            step();
        end
        n_checks++;
        if (req_ready !== 4'b0001 || timeout !== 1'b0 || req_rdata !== 4'h7) begin
            n_fail++; $display("FAIL to_limit_win: got ready=%b to=%b rdata=%h expected 0001 0 7", req_ready, timeout, req_rdata);
        end
        req_valid     = 4'b0000;
        tgt_ready_drv = 1'b0;
        step();
`else
        for (int c = 1; c <= 20; c++) step();
        n_checks++;
        if (tgt_valid !== 1'b1 || timeout !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL no_wd_wait: got tv=%b to=%b ready=%b expected 1 0 0000", tgt_valid, timeout, req_ready);
        end
        tgt_ready_drv = 1'b1;
        step();
        n_checks++;
        if (req_ready !== 4'b0001 || req_rdata !== 4'h6) begin
            n_fail++; $display("FAIL no_wd_resp: got ready=%b rdata=%h expected 0001 6", req_ready, req_rdata);
        end
        req_valid     = 4'b0000;
        tgt_ready_drv = 1'b0;
        step();
`endif
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        req_valid = 4'b0001;
        tgt_rdata = 4'h9;
        step();
        step();
        req_valid = 4'b0011;
        step();
        auto_ready    = 1'b0;
        tgt_ready_drv = 1'b0;
        step();
        n_checks++;
        if (grant !== 4'b0010 || tgt_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: got grant=%b tv=%b expected 0010 1", grant, tgt_valid);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (grant !== 4'b0000 || req_ready !== 4'b0000 || req_rdata !== 4'h0 ||
            {tgt_valid, busy, timeout} !== 3'b000) begin
            n_fail++; $display("FAIL mid_reset: got grant=%b ready=%b rdata=%h tv/busy/to=%b expected 0000 0000 0 000",
                               grant, req_ready, req_rdata, {tgt_valid, busy, timeout});
        end
        auto_ready = 1'b1;
        tgt_rdata  = 4'hC;
        step();
        n_checks++;
        if (grant !== 4'b0001 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL mid_priority: got grant=%b ready=%b expected 0001 0000", grant, req_ready);
        end
        step();
        n_checks++;
        if (req_ready !== 4'b0001 || req_rdata !== 4'hC) begin
            n_fail++; $display("FAIL mid_resp: got ready=%b rdata=%h expected 0001 c", req_ready, req_rdata);
        end
        req_valid = 4'b0000;
        step();
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = 4'b0000;
        auto_ready    = 1'b1;
        tgt_ready_drv = 1'b0;
        tgt_rdata     = 4'h0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_stall();
        test_timeout();
        test_reset_mid_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
